// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART receive front end with a one-entry valid/ready holding stage.
// Build option UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote of samples at sc=6/7/8 instead of sc=7.
module uart_rx_frame #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       rx,
  input  logic       rx_en,
  input  logic [7:0] baud_div,
  input  logic [3:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop2,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  input  logic       ovr_clr,
  output logic       rx_busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [3:0] SC_LAST = 4'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] SC_DECIDE = 4'(OVS / 2);
`else
  localparam logic [3:0] SC_DECIDE = 4'(OVS / 2 - 1);
`endif

  state_t     r_state, w_state_nxt;
  logic       r_rx_meta, r_rx_sync;
  logic [7:0] r_tick_cnt;
  logic [3:0] r_sc, r_bit_cnt, r_nbits;
  logic       r_par_en, r_par_odd, r_stop2, r_stop_cnt;
  logic [7:0] r_shift, r_data;
  logic       r_perr_acc, r_ferr_acc;
  logic       r_perr, r_ferr, r_valid, r_overrun;
  logic       w_tick, w_samp, w_bit_end, w_bit, w_start, w_done;
  logic       w_load, w_drop, w_ferr_fin;
  logic [3:0] w_nbits_in;

  // NOTE: sequential state uses <= so every flop updates from pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_tick = rx_en && (r_tick_cnt == baud_div);

  always_ff @(posedge clk) begin
    if (srst || !rx_en || w_tick) r_tick_cnt <= '0;
    else                          r_tick_cnt <= r_tick_cnt + 8'd1;
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_s6, r_s7;
  always_ff @(posedge clk) begin
    if (srst) begin
      r_s6 <= 1'b1;
      r_s7 <= 1'b1;
    end else if (w_tick && r_sc == SC_DECIDE - 4'd2) begin
      r_s6 <= r_rx_sync;
    end else if (w_tick && r_sc == SC_DECIDE - 4'd1) begin
      r_s7 <= r_rx_sync;
    end
  end
  assign w_bit = (r_s6 & r_s7) | (r_s6 & r_rx_sync) | (r_s7 & r_rx_sync);
`else
  assign w_bit = r_rx_sync;
`endif

  assign w_samp     = w_tick && (r_sc == SC_DECIDE);
  assign w_bit_end  = w_tick && (r_sc == SC_LAST);
  assign w_nbits_in = (data_bits >= 4'd5 && data_bits <= 4'd8) ? data_bits : 4'd8;

  always_ff @(posedge clk) begin
    if (srst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (!r_rx_sync) begin
        w_state_nxt = S_START;
        w_start     = 1'b1;
      end
      S_START: begin
        if (w_samp && w_bit)  w_state_nxt = S_IDLE;
        else if (w_bit_end)   w_state_nxt = S_DATA;
      end
      S_DATA: if (w_bit_end && r_bit_cnt == r_nbits - 4'd1)
        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      S_STOP: if (w_samp && (!r_stop2 || r_stop_cnt)) begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rx_en) begin
      w_state_nxt = S_IDLE;
      w_start     = 1'b0;
      w_done      = 1'b0;
    end
  end

  // Frame datapath; configuration is captured at start so mid-frame changes wait for the next frame.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_sc       <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_nbits    <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_stop2    <= 1'b0;
    end else if (w_start) begin
      r_sc       <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_nbits    <= w_nbits_in;
      r_par_en   <= parity_en;
      r_par_odd  <= parity_odd;
      r_stop2    <= stop2;
    end else if (r_state != S_IDLE && w_tick) begin
      r_sc <= r_sc + 4'd1;
      case (r_state)
        S_DATA: begin
          if (w_samp)    r_shift[r_bit_cnt[2:0]] <= w_bit;
          if (w_bit_end) r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        S_PARITY: if (w_samp) r_perr_acc <= (^r_shift) ^ w_bit ^ r_par_odd;
        S_STOP: begin
          if (w_samp && !w_bit) r_ferr_acc <= 1'b1;
          if (w_bit_end)        r_stop_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_ferr_fin = r_ferr_acc | ~w_bit;
  assign w_load     = w_done && (!r_valid || rx_ready);
  assign w_drop     = w_done && r_valid && !rx_ready;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_data    <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_perr  <= r_perr_acc;
        r_ferr  <= w_ferr_fin;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop)       r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;
    end
  end

  assign rx_data    = r_data;
  assign rx_perr    = r_perr;
  assign rx_ferr    = r_ferr;
  assign rx_valid   = r_valid;
  assign rx_overrun = r_overrun;
  assign rx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames against a
// queue-based character model that is compared on every cycle the holding register is full.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       srst, rx, rx_en, parity_en, parity_odd, stop2, ovr_clr;
  logic [7:0] baud_div;
  logic [3:0] data_bits;
  logic       rx_ready, rdy_dir, rdy_rnd;
  logic [7:0] rx_data;
  logic       rx_perr, rx_ferr, rx_valid, rx_overrun, rx_busy;
  bit         rand_ready = 1'b0;

  always #5 clk = ~clk;
  assign rx_ready = rand_ready ? rdy_rnd : rdy_dir;

  uart_rx_frame dut (
    .clk(clk), .srst(srst), .rx(rx), .rx_en(rx_en), .baud_div(baud_div),
    .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overrun(rx_overrun), .ovr_clr(ovr_clr), .rx_busy(rx_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } char_t;

  char_t exp_q[$];
  char_t last_acc;
  int    total = 0, bad = 0;
  int    cyc = 0, rise_cyc = 0, frames_seen = 0, frame_start_cyc = 0;
  logic  prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rand_ready) begin
      #1 rdy_rnd = 1'($urandom_range(0, 1));
    end
  end

  // Compare process: whenever the holding register is full it must equal the oldest expected character.
  always @(negedge clk) begin
    if (srst !== 1'b1) begin
      if (rx_valid === 1'b1) begin
        if (prev_valid !== 1'b1) begin
          rise_cyc = cyc;
          frames_seen++;
        end
        if (exp_q.size() == 0) begin
          check("valid_without_expected", {31'd0, rx_valid}, 32'd0);
        end else begin
          check("data", {24'd0, rx_data}, {24'd0, exp_q[0].data});
          check("perr", {31'd0, rx_perr}, {31'd0, exp_q[0].perr});
          check("ferr", {31'd0, rx_ferr}, {31'd0, exp_q[0].ferr});
          if (rx_ready === 1'b1) begin
            last_acc = {rx_data, rx_perr, rx_ferr};
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = rx_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_clks();
    return (int'(baud_div) + 1) * 16;
  endfunction

  task automatic idle_bits(input int n);
    drive_bit(1'b1, n * bit_clks());
  endtask

  task automatic send_stop(input bit bad_bit, input int bclk);
    if (bad_bit) begin
      drive_bit(1'b0, (bclk * 3) / 4);
      drive_bit(1'b1, bclk - (bclk * 3) / 4);
    end else begin
      drive_bit(1'b1, bclk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [3:0] db, input bit pe, input bit po,
                            input bit s2, input bit bad_par, input bit bad_s1, input bit bad_s2,
                            input bit push, input bit scramble);
    int         bclk, nb;
    logic [7:0] dm;
    logic       pbit;
    char_t      e;
    data_bits  = db;
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
    bclk = bit_clks();
    nb   = (db >= 4'd5 && db <= 4'd8) ? int'(db) : 8;
    dm   = d & 8'((1 << nb) - 1);
    pbit = (^dm) ^ po ^ bad_par;
    e.data = dm;
    e.perr = pe & bad_par;
    e.ferr = bad_s1 | (s2 & bad_s2);
    if (push) exp_q.push_back(e);
    frame_start_cyc = cyc;
    drive_bit(1'b0, bclk);
    if (scramble) begin
      data_bits  = 4'($urandom);
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2      = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) drive_bit(dm[i], bclk);
    if (pe) drive_bit(pbit, bclk);
    send_stop(bad_s1, bclk);
    if (s2) send_stop(bad_s2, bclk);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rx_valid === 1'b1) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, (n < 5000)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   {31'd0, rx_valid},   32'd0);
    check({tag, "_data"},    {24'd0, rx_data},    32'd0);
    check({tag, "_perr"},    {31'd0, rx_perr},    32'd0);
    check({tag, "_ferr"},    {31'd0, rx_ferr},    32'd0);
    check({tag, "_overrun"}, {31'd0, rx_overrun}, 32'd0);
    check({tag, "_busy"},    {31'd0, rx_busy},    32'd0);
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int seen, lat, bd, r;
    logic [3:0] db;
    bit pe, s2;
    srst = 1'b1; rx = 1'b1; rx_en = 1'b0; baud_div = 8'd0; data_bits = 4'd8;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; rdy_dir = 1'b1; rdy_rnd = 1'b1;
    ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    srst  = 1'b0;
    rx_en = 1'b1;
    drive_bit(1'b1, 20);

    // 8N1 at full tick rate: value and start-edge-to-valid latency
    send_frame(8'hA5, 4'd8, 0, 0, 0, 0, 0, 0, 1, 0);
    lat = rise_cyc - frame_start_cyc;
    check("latency_in_window", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
    idle_bits(1);
    wait_drain("a5_drain");
    check("a5_data", {24'd0, last_acc.data}, 32'hA5);
    check("a5_flags", {30'd0, last_acc.perr, last_acc.ferr}, 32'd0);
    check("a5_count", frames_seen, 32'd1);

    // 7E1: wrong then right parity bit
    send_frame(8'h35, 4'd7, 1, 0, 0, 1, 0, 0, 1, 0);
    idle_bits(1);
    wait_drain("par_bad_drain");
    check("par_bad_data", {24'd0, last_acc.data}, 32'h35);
    check("par_bad_perr", {31'd0, last_acc.perr}, 32'd1);
    send_frame(8'h35, 4'd7, 1, 0, 0, 0, 0, 0, 1, 0);
    idle_bits(1);
    wait_drain("par_ok_drain");
    check("par_ok_perr", {31'd0, last_acc.perr}, 32'd0);

    // 8N2 with a low second stop bit, then a clean frame
    send_frame(8'h3C, 4'd8, 0, 0, 1, 0, 0, 1, 1, 0);
    idle_bits(2);
    wait_drain("ferr_drain");
    check("ferr_data", {24'd0, last_acc.data}, 32'h3C);
    check("ferr_flag", {31'd0, last_acc.ferr}, 32'd1);
    send_frame(8'h3C, 4'd8, 0, 0, 1, 0, 0, 0, 1, 0);
    idle_bits(1);
    wait_drain("stop_ok_drain");
    check("stop_ok_ferr", {31'd0, last_acc.ferr}, 32'd0);

    // Overrun: second character dropped while the first is held
    rdy_dir = 1'b0;
    send_frame(8'h11, 4'd8, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_bits(1);
    send_frame(8'h22, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_bits(1);
    check("ovr_set", {31'd0, rx_overrun}, 32'd1);
    check("ovr_held_data", {24'd0, rx_data}, 32'h11);
    rdy_dir = 1'b1;
    wait_drain("ovr_drain");
    check("ovr_accepted", {24'd0, last_acc.data}, 32'h11);
    check("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
    ovr_clr = 1'b1;
    drive_bit(1'b1, 1);
    ovr_clr = 1'b0;
    check("ovr_cleared", {31'd0, rx_overrun}, 32'd0);

    // 4-clk low glitch is a false start
    seen = frames_seen;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2);
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    drive_bit(1'b1, 8);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    idle_bits(3);
    check("glitch_no_frame", frames_seen, seen);

    // rx_en dropped mid-frame discards the partial character
    drive_bit(1'b0, 48);
    check("en_busy_mid", {31'd0, rx_busy}, 32'd1);
    rx_en = 1'b0;
    drive_bit(1'b1, 2);
    check("en_busy_off", {31'd0, rx_busy}, 32'd0);
    drive_bit(1'b1, 10);
    rx_en = 1'b1;
    idle_bits(3);
    check("en_no_frame", frames_seen, seen);

    // Synchronous reset in the middle of DATA while a character and overrun are held
    rdy_dir = 1'b0;
    send_frame(8'h77, 4'd8, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_bits(1);
    send_frame(8'h88, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_bits(1);
    check("pre_srst_ovr", {31'd0, rx_overrun}, 32'd1);
    drive_bit(1'b0, 48);
    srst = 1'b1;
    rx   = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    srst = 1'b0;
    check_reset_outputs("srst");
    rdy_dir = 1'b1;
    idle_bits(2);
    send_frame(8'h5A, 4'd8, 0, 0, 0, 0, 0, 0, 1, 0);
    idle_bits(1);
    wait_drain("post_srst_drain");
    check("post_srst_data", {24'd0, last_acc.data}, 32'h5A);

    // Randomized frames: baud, length, parity, stop bits, error injection, mid-frame config noise
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bd = $urandom_range(0, 2);
      rx_en = 1'b0;
      baud_div = 8'(bd);
      drive_bit(1'b1, 1);
      rx_en = 1'b1;
      r = $urandom_range(0, 9);
      if (r < 8) db = 4'(5 + (r % 4));
      else       db = 4'($urandom_range(9, 15));
      pe = 1'($urandom);
      s2 = 1'($urandom);
      send_frame(8'($urandom), db, pe, 1'($urandom), s2,
                 pe && ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 s2 && ($urandom_range(0, 5) == 0), 1, 1);
      idle_bits($urandom_range(1, 3));
      wait_drain("rand_drain");
      check("rand_no_overrun", {31'd0, rx_overrun}, 32'd0);
    end
    rand_ready = 1'b0;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
